// File: rtl/imul_iter_var_if.sv
// Request/response stream bundle for the iterative multiplier.
// The master side issues operands and consumes products; the slave side is the multiplier.
interface imul_iter_var_if #(
    parameter int NBITS = 32
);
    logic                 istream_val;
    logic                 istream_rdy;
    logic [2*NBITS-1:0]   istream_msg;
    logic [1:0]           istream_mode;
    logic                 ostream_val;
    logic                 ostream_rdy;
    logic [NBITS-1:0]     ostream_msg;

    modport master (
        output istream_val,
        output istream_msg,
        output istream_mode,
        output ostream_rdy,
        input  istream_rdy,
        input  ostream_val,
        input  ostream_msg
    );

    modport slave (
        input  istream_val,
        input  istream_msg,
        input  istream_mode,
        input  ostream_rdy,
        output istream_rdy,
        output ostream_val,
        output ostream_msg
    );
endinterface

// File: rtl/imul_iter_var.sv
// Variable-latency iterative multiplier: shift-add on operand magnitudes with runs of
// trailing multiplier zeros skipped (up to MAX_SHIFT per cycle) and sign fixed up at the end.
//
// state | meaning
// IDLE  | ready for a request, no response pending
// CALC  | one shift/add step per cycle until the multiplier magnitude is exhausted
// DONE  | response valid, held until the consumer takes it
module imul_iter_var #(
    parameter int NBITS     = 32,
    parameter int MAX_SHIFT = 4
) (
    input  logic           clk,
    input  logic           reset,
    imul_iter_var_if.slave io
);
    localparam int KW = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [2*NBITS-1:0]   acc_a;
    logic [2*NBITS-1:0]   prod;
    logic [NBITS-1:0]     mul_b;
    logic                 neg;
    logic                 hi;
    logic                 rdy_q;
    logic                 val_q;
    logic [NBITS-1:0]     msg_q;

    logic [NBITS-1:0]     a_in;
    logic [NBITS-1:0]     b_in;
    logic [NBITS-1:0]     a_mag;
    logic [NBITS-1:0]     b_mag;
    logic                 neg_in;
    logic [KW-1:0]        skip;
    logic [2*NBITS-1:0]   a_next;
    logic [2*NBITS-1:0]   p_next;
    logic [NBITS-1:0]     b_next;
    logic [2*NBITS-1:0]   result;

    // Counts trailing zeros, saturating at MAX_SHIFT (an all-zero value yields MAX_SHIFT).
    function automatic logic [KW-1:0] trailing_zeros(input logic [NBITS-1:0] v);
        logic [KW-1:0] n;
        logic          stop;
        n    = '0;
        stop = 1'b0;
        for (int i = 0; i < MAX_SHIFT; i++) begin
            if (!stop && !v[i])
                n = n + KW'(1);
            else
                stop = 1'b1;
        end
        return n;
    endfunction

    // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
    always_comb begin
        a_in   = io.istream_msg[2*NBITS-1:NBITS];
        b_in   = io.istream_msg[NBITS-1:0];
        a_mag  = (io.istream_mode[0] && a_in[NBITS-1]) ? -a_in : a_in;
        b_mag  = (io.istream_mode[0] && b_in[NBITS-1]) ? -b_in : b_in;
        neg_in = io.istream_mode[0] & (a_in[NBITS-1] ^ b_in[NBITS-1]);
    end

    always_comb begin
        skip = trailing_zeros(mul_b);
        if (mul_b[0]) begin
            p_next = prod + acc_a;
            a_next = acc_a << 1;
            b_next = mul_b >> 1;
        end else begin
            p_next = prod;
            a_next = acc_a << skip;
            b_next = mul_b >> skip;
        end
        result = neg ? -p_next : p_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc_a <= '0;
            prod  <= '0;
            mul_b <= '0;
            neg   <= 1'b0;
            hi    <= 1'b0;
            rdy_q <= 1'b0;
            val_q <= 1'b0;
            msg_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    val_q <= 1'b0;
                    if (io.istream_val && rdy_q) begin
                        acc_a <= {{NBITS{1'b0}}, a_mag};
                        mul_b <= b_mag;
                        prod  <= '0;
                        neg   <= neg_in;
                        hi    <= io.istream_mode[1];
                        rdy_q <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc_a <= a_next;
                    mul_b <= b_next;
                    prod  <= p_next;
                    // A zero multiplier also lands here: the skip path leaves it zero.
                    if (b_next == '0) begin
                        state <= DONE;
                        val_q <= 1'b1;
                        msg_q <= hi ? result[2*NBITS-1:NBITS] : result[NBITS-1:0];
                    end
                end
                DONE: begin
                    if (io.ostream_rdy) begin
                        state <= IDLE;
                        val_q <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    val_q <= 1'b0;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.istream_rdy = rdy_q;
    assign io.ostream_val = val_q;
    assign io.ostream_msg = msg_q;
endmodule

// File: tb/tb_imul_iter_var.sv
// Scoreboard bench for imul_iter_var (NBITS=32, MAX_SHIFT=4): products, latency,
// backpressure and mid-operation reset.
module tb_imul_iter_var;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q[$];

    imul_iter_var_if #(.NBITS(32)) io ();

    imul_iter_var #(.NBITS(32), .MAX_SHIFT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] mode);
        logic [63:0] p;
        if (mode[0])
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else
            p = {32'b0, a} * {32'b0, b};
        return mode[1] ? p[63:32] : p[31:0];
    endfunction

    // Steps taken: one per set bit, one per run of up to 4 zeros below the top set bit.
    function automatic int lat_model(input logic [31:0] b, input logic [1:0] mode);
        logic [31:0] m;
        int c;
        int k;
        m = (mode[0] && b[31]) ? -b : b;
        c = 0;
        if (m == 0) return 1;
        while (m != 0) begin
            if (m[0]) begin
                m = m >> 1;
            end else begin
                k = 0;
                while (k < 4 && !m[k]) k++;
                m = m >> k;
            end
            c++;
        end
        return c;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
        int   n;
        logic acc;
        io.istream_val  = 1'b1;
        io.istream_msg  = {a, b};
        io.istream_mode = mode;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = io.istream_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        io.istream_val  = 1'b0;
        io.istream_msg  = {$urandom, $urandom};
        io.istream_mode = ~mode;
        chk("accept", {63'b0, acc}, 64'd1);
        exp_q.push_back(ref_mul(a, b, mode));
    endtask

    task automatic recv(input int exp_lat, input int hold);
        int          n;
        logic [31:0] exp;
        n = 0;
        while (!io.ostream_val && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        chk("rsp_val", {63'b0, io.ostream_val}, 64'd1);
        chk("latency", 64'(n), 64'(exp_lat));
        chk("rsp_msg", {32'b0, io.ostream_msg}, {32'b0, exp});
        chk("busy_rdy", {63'b0, io.istream_rdy}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_val", {63'b0, io.ostream_val}, 64'd1);
            chk("hold_msg", {32'b0, io.ostream_msg}, {32'b0, exp});
            chk("hold_rdy", {63'b0, io.istream_rdy}, 64'd0);
        end
        io.ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        io.ostream_rdy = 1'b0;
        chk("rsp_drop", {63'b0, io.ostream_val}, 64'd0);
        chk("idle_rdy", {63'b0, io.istream_rdy}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        reset           = 1'b0;
        io.istream_val  = 1'b0;
        io.istream_msg  = '0;
        io.istream_mode = '0;
        io.ostream_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", {63'b0, io.ostream_val}, 64'd0);
        chk("rst_msg", {32'b0, io.ostream_msg}, 64'd0);
        chk("rst_rdy", {63'b0, io.istream_rdy}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", {63'b0, io.istream_rdy}, 64'd1);

        send(32'd3, 32'd4, 2'b00);                 recv(2, 0);
        send(32'hDEADBEEF, 32'd0, 2'b00);          recv(1, 0);
        send(32'hDEADBEEF, 32'd0, 2'b11);          recv(1, 0);
        send(-32'sd7, 32'd6, 2'b01);               recv(lat_model(32'd6, 2'b01), 0);
        send(-32'sd7, 32'd6, 2'b11);               recv(lat_model(32'd6, 2'b11), 0);
        send(32'h80000000, 32'h80000000, 2'b11);   recv(9, 0);
        send(32'h80000000, 32'h80000000, 2'b01);   recv(9, 0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);   recv(32, 0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);   recv(32, 0);
        send(32'd5, 32'd5, 2'b00);                 recv(3, 5);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rm = 2'($urandom_range(0, 3));
            send(ra, rb, rm);
            recv(lat_model(rb, rm), 0);
        end

        send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
        exp_q.delete();
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_val", {63'b0, io.ostream_val}, 64'd0);
        chk("midrst_rdy", {63'b0, io.istream_rdy}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rdy", {63'b0, io.istream_rdy}, 64'd1);
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("no_stale", {63'b0, io.ostream_val}, 64'd0);
        end
        send(32'd5, 32'd5, 2'b00);                 recv(3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imul_iter_var.md
Name: imul_iter_var

Overview:
- Parametrised successor to the fixed 32-bit base iterative multiplier.
- Generalised operand width, with signed/unsigned mode and low/high product-half select.
- Variable-latency zero-skipping: runs of trailing zeros in the multiplier are shifted over in one step, with early termination when the multiplier is exhausted.
- Sits behind a val/rdy request stream and drives a val/rdy response stream, as a drop-in for the existing multiplier test benches.

Parameters:
- NBITS, 32, operand and result width.
- MAX_SHIFT, 4, maximum zero bits skipped per cycle; range 1..NBITS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- istream_val  input  1  request valid.
- istream_rdy  output  1  request ready.
- istream_msg  input  2*NBITS  {a[2N-1:N], b[N-1:0]}.
- istream_mode  input  2  bit0 = signed, bit1 = return high half; sampled with msg.
- ostream_val  output  1  response valid.
- ostream_rdy  input  1  response ready.
- ostream_msg  output  NBITS  selected product half.

Behaviour:
- States: IDLE, CALC, DONE. Reset forces IDLE immediately.
- Reset output values: ostream_val=0, ostream_msg=0, istream_rdy=0 while reset is low. istream_rdy goes to 1 from the first cycle after release.
- IDLE: istream_rdy=1, ostream_val=0. On istream_val&istream_rdy at a posedge:
  - Latch A = |a| zero-extended to 2N bits, and B = |b| (N bits).
  - Latch neg = signed & (a[N-1]^b[N-1]), and hi = mode[1].
  - Set P=0. Go to CALC.
  - When unsigned, |x| = x. -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits.
- CALC: istream_rdy=0, ostream_val=0. One step per cycle:
  - B==0: no change; go to DONE.
  - B[0]==1: P += A; A <<= 1; B >>= 1.
  - B[0]==0: k = min(trailing zeros of B, MAX_SHIFT); A <<= k; B >>= k.
  - Go to DONE in the same cycle the post-step B is 0; otherwise stay in CALC.
- DONE: ostream_val=1, istream_rdy=0.
  - R = neg ? -P : P, computed modulo 2^(2N).
  - ostream_msg = hi ? R[2N-1:N] : R[N-1:0]. It is stable while ostream_val=1 and ostream_rdy=0.
  - On ostream_rdy=1: go to IDLE.
  - No same-cycle accept in DONE; the next request is accepted at the earliest one cycle later.
- Latency: ostream_val rises C cycles after the accepting edge, where C = number of CALC steps (C >= 1).
  - Unsigned with MAX_SHIFT=NBITS: C = popcount(b)+(number of zero runs below the MSB set bit), minimum 1.
  - Worst case is NBITS cycles (all ones).
- Arithmetic: the full 2N-bit product is always formed. The result equals a*b with both operands signed or both unsigned according to mode[0].
- Reset mid-CALC/DONE: the transaction is discarded and no response is produced.
- Inputs are ignored outside IDLE.
- istream_mode is ignored unless accepted.

Test Plan (NBITS=32, MAX_SHIFT=4):
- Unsigned lo, a=3, b=4 -> ostream_msg=12. ostream_val 2 cycles after accept (skip 2, then add).
- Zero multiplier, a=0xDEADBEEF, b=0, any mode -> ostream_msg=0. ostream_val exactly 1 cycle after accept.
- Signed cases:
  - a=-7, b=6, lo -> 0xFFFFFFD6.
  - Same operands, hi -> 0xFFFFFFFF.
  - a=b=0x80000000, signed, hi -> 0x40000000, lo -> 0x00000000.
- Unsigned hi, a=b=0xFFFFFFFF -> 0xFFFFFFFE; lo -> 0x00000001. Latency 32 cycles.
- Backpressure: hold ostream_rdy=0 for 5 cycles after ostream_val rises on 5*5 -> msg stays 25 and val stays 1. istream_rdy=0 throughout; transaction completes 1 cycle after ostream_rdy=1.
- Reset mid-op: pulse reset low during CALC of 0xFFFFFFFF*0xFFFFFFFF -> ostream_val=0 and istream_rdy=0 immediately. After release istream_rdy=1; the next request 5*5 returns 25 with no stale response.
